// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the MEM-stage data memory responder: RV32I load/store funct3
// codes, responder FSM state encodings and the funct3 legality check.
package data_mem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } rsp_state_e;

    function automatic logic funct3_legal(input logic wen, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (wen) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering for one 32-bit word: extends load data from the addressed lane
// and merges store data into the old word. Purely combinational.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [4:0]  bit_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign bit_sh  = {addr_lo, 3'b000};
    assign half_sh = {addr_lo[1], 4'b0000};

    always_comb begin
        lane_b = 8'(old_word >> bit_sh);
        lane_h = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        load_val = '0;
        case (funct3)
            F3_LB:   load_val = {{24{lane_b[7]}}, lane_b};
            F3_LH:   load_val = {{16{lane_h[15]}}, lane_h};
            F3_LW:   load_val = old_word;
            F3_LBU:  load_val = {24'd0, lane_b};
            F3_LHU:  load_val = {16'd0, lane_h};
            default: load_val = '0;
        endcase

        store_word = old_word;
        case (funct3)
            F3_SB:   store_word[bit_sh +: 8]   = wdata[7:0];
            F3_SH:   store_word[half_sh +: 16] = wdata[15:0];
            F3_SW:   store_word                = wdata;
            default: store_word                = old_word;
        endcase

        // funct3[1:0] encodes access size for every legal load and store
        misalign = ((funct3[1:0] == 2'd1) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'd2) && (addr_lo != 2'b00));
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency valid/ready data memory for the MEM-stage load/store port.
// One request in flight; store commit and response registration share the RESP-entry edge.
//
//   state    | meaning
//   RSP_IDLE | ready for a request, req_ready high
//   RSP_WAIT | request latched, latency counter running down
//   RSP_RESP | response held until rsp_valid && rsp_ready
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int  AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit  LAT_ONE = (LATENCY == 1);

    rsp_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] lat_addr;
    logic        lat_wen;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_wdata;

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic [31:0] cur_addr;
    logic        cur_wen;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0] old_word;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        misalign;
    logic        out_of_range;
    logic        op_err;

    assign req_ready = (state_q == RSP_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // With LATENCY==1 the accept edge is also the RESP-entry edge, so the live
    // request feeds the datapath while idle; otherwise the latched copy does.
    assign cur_addr   = (state_q == RSP_IDLE) ? req_addr   : lat_addr;
    assign cur_wen    = (state_q == RSP_IDLE) ? req_wen    : lat_wen;
    assign cur_funct3 = (state_q == RSP_IDLE) ? req_funct3 : lat_funct3;
    assign cur_wdata  = (state_q == RSP_IDLE) ? req_wdata  : lat_wdata;

    assign word_idx     = cur_addr[AW+1:2];
    assign out_of_range = (cur_addr[31:2] >= 30'(DEPTH_WORDS));
    assign old_word     = mem[word_idx];
    assign op_err       = out_of_range || misalign || !funct3_legal(cur_wen, cur_funct3);

    mem_lane_align u_lane_align (
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .old_word   (old_word),
        .wdata      (cur_wdata),
        .load_val   (load_val),
        .store_word (store_word),
        .misalign   (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RSP_IDLE: begin
                if (accept) begin
                    if (LAT_ONE) begin
                        state_d = RSP_RESP;
                    end else begin
                        state_d = RSP_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            RSP_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RSP_RESP;
                end
            end
            RSP_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = RSP_IDLE;
                end
            end
            default: begin
                state_d = RSP_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign enter_resp = (state_d == RSP_RESP) && (state_q != RSP_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RSP_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            lat_addr    <= '0;
            lat_wen     <= 1'b0;
            lat_funct3  <= '0;
            lat_wdata   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_addr   <= req_addr;
                lat_wen    <= req_wen;
                lat_funct3 <= req_funct3;
                lat_wdata  <= req_wdata;
            end
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= op_err;
                rsp_rdata_q <= (op_err || cur_wen) ? 32'd0 : load_val;
            end else if (state_q == RSP_RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Array contents survive reset; a store dropped by reset never reaches here.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_wen && !op_err) begin
            mem[word_idx] <= store_word;
        end
    end

endmodule
